// File: rtl/nios_system_nrf_irq.sv
// Avalon-MM input port for the nRF24L01 active-low IRQ pin: sync, optional glitch filter
// (NRF_IRQ_DEBOUNCE_EN), falling-edge capture and a maskable level interrupt.
module nios_system_nrf_irq #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  logic r_s1;
  logic r_s2;
  logic r_lvl_d;
  logic r_edge_cap;
  logic r_irq_mask;
  logic w_lvl;
  logic w_fall;
  logic w_clear;
  logic w_mask_wr;
  logic w_unused_wdata;

  assign w_clear        = chipselect & ~write_n & (address == 2'd3);
  assign w_mask_wr      = chipselect & ~write_n & (address == 2'd2);
  assign w_fall         = r_lvl_d & ~w_lvl;
  assign w_unused_wdata = ^writedata[31:1];

  // Idle-high reset values keep reset from looking like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_lvl_d <= 1'b1;
    end else begin
      r_s1    <= in_port;
      r_s2    <= r_s1;
      r_lvl_d <= w_lvl;
    end
  end

`ifdef NRF_IRQ_DEBOUNCE_EN
  localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);

  logic        r_lvl;
  logic [15:0] r_cnt;

  // Level follows the pin only after it has disagreed for DEBOUNCE_CYCLES clocks in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lvl <= 1'b1;
      r_cnt <= 16'd0;
    end else if (r_s2 == r_lvl) begin
      r_cnt <= 16'd0;
    end else if (r_cnt == CntMax) begin
      r_lvl <= r_s2;
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign w_lvl = r_lvl;
`else
  localparam int unsigned unused_debounce = DEBOUNCE_CYCLES;

  assign w_lvl = r_s2;
`endif

  // A fall coinciding with a clear write keeps the capture set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cap <= 1'b0;
      r_irq_mask <= 1'b0;
    end else begin
      r_edge_cap <= w_fall | (r_edge_cap & ~w_clear);
      if (w_mask_wr) begin
        r_irq_mask <= writedata[0];
      end
    end
  end

  assign irq = r_edge_cap & r_irq_mask;

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata[0] = w_lvl;
      2'd2:    readdata[0] = r_irq_mask;
      2'd3:    readdata[0] = r_edge_cap;
      default: readdata    = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_nios_system_nrf_irq.sv
// Self-checking bench for nios_system_nrf_irq; reference model works from pin-sample history.
module tb_nios_system_nrf_irq;

`ifdef NRF_IRQ_DEBOUNCE_EN
  localparam int unsigned DB  = 4;
  localparam int unsigned LAT = 4;
`else
  localparam int unsigned DB  = 16;
  localparam int unsigned LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic        in_port;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Reference model: pin sample and filtered-level history rings, indexed by edge count.
  bit pin_h[64];
  bit lvl_h[64];
  int k;
  bit m_cap;
  bit m_mask;

  nios_system_nrf_irq #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      pin_h[i] = 1'b1;
      lvl_h[i] = 1'b1;
    end
    k      = 1000;
    m_cap  = 1'b0;
    m_mask = 1'b0;
  endtask

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    case (a)
      2'd0:    return {31'd0, lvl_h[k & 63]};
      2'd2:    return {31'd0, m_mask};
      2'd3:    return {31'd0, m_cap};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: update the model with the inputs held across the edge, return at negedge.
  task automatic cycle();
    bit prev;
    bit flip;
    bit fall;
    bit wr;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      k = k + 1;
      pin_h[k & 63] = in_port;
      prev = lvl_h[(k - 1) & 63];
`ifdef NRF_IRQ_DEBOUNCE_EN
      flip = 1'b1;
      for (int j = 0; j < int'(DB); j++) begin
        if (pin_h[(k - 2 - j) & 63] == prev) flip = 1'b0;
      end
      lvl_h[k & 63] = flip ? ~prev : prev;
`else
      flip = 1'b0;
      lvl_h[k & 63] = pin_h[(k - 1) & 63] ^ flip;
`endif
      fall = lvl_h[(k - 2) & 63] & ~prev;
      wr = chipselect & ~write_n;
      m_cap = fall | (m_cap & ~(wr && address == 2'd3));
      if (wr && address == 2'd2) m_mask = writedata[0];
    end
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic settle_high();
    in_port = 1'b1;
    repeat (LAT + 6) cycle();
  endtask

  task automatic test_reset();
    logic [31:0] rexp [4];
    rexp = '{32'd1, 32'd0, 32'd0, 32'd0};
    reset_n = 1'b0;
    model_reset();
    repeat (3) cycle();
    reset_n = 1'b1;
    repeat (4) cycle();
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      total++;
      if (readdata !== rexp[a]) begin
        bad++;
        $display("FAIL reset_read addr=%0d got=%h want=%h", a, readdata, rexp[a]);
      end
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq got=%b want=0", irq);
    end
  endtask

  task automatic test_edge();
    int n;
    bit seen;
    bus_write(2'd2, 32'd1);
    settle_high();
    in_port = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      cycle();
      n++;
      total++;
      if (irq !== (m_cap & m_mask)) begin
        bad++;
        $display("FAIL edge_irq cyc=%0d got=%b want=%b", n, irq, m_cap & m_mask);
      end
      if (irq === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || n != int'(3 + LAT)) begin
      bad++;
      $display("FAIL edge_latency got=%0d want=%0d", n, 3 + LAT);
    end
    bus_write(2'd3, 32'd0);
    address = 2'd3;
    #1;
    total++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL edge_clear got cap=%h irq=%b want cap=0 irq=0", readdata, irq);
    end
    in_port = 1'b1;
    repeat (LAT + 8) cycle();
    total++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL rise_ignored got cap=%h irq=%b want cap=0 irq=0", readdata, irq);
    end
  endtask

  task automatic test_mask();
    bus_write(2'd2, 32'd0);
    settle_high();
    in_port = 1'b0;
    repeat (LAT + 6) cycle();
    address = 2'd3;
    #1;
    total++;
    if (readdata !== 32'd1 || irq !== 1'b0) begin
      bad++;
      $display("FAIL mask_off got cap=%h irq=%b want cap=1 irq=0", readdata, irq);
    end
    bus_write(2'd2, 32'hFFFF_FFF1);
    address = 2'd2;
    #1;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL mask_on_irq got=%b want=1", irq);
    end
    total++;
    if (readdata !== 32'h0000_0001) begin
      bad++;
      $display("FAIL mask_read got=%h want=00000001", readdata);
    end
  endtask

  task automatic test_clear_collision();
    settle_high();
    in_port = 1'b0;
    repeat (LAT + 2) cycle();
    bus_write(2'd3, 32'hDEAD_BEEF);
    address = 2'd3;
    #1;
    total++;
    if (readdata !== 32'd1 || irq !== 1'b1) begin
      bad++;
      $display("FAIL clear_collision got cap=%h irq=%b want cap=1 irq=1", readdata, irq);
    end
    total++;
    if (readdata !== exp_read(2'd3)) begin
      bad++;
      $display("FAIL clear_collision_model got=%h want=%h", readdata, exp_read(2'd3));
    end
  endtask

`ifdef NRF_IRQ_DEBOUNCE_EN
  task automatic test_glitch();
    int n;
    bit seen;
    settle_high();
    bus_write(2'd3, 32'd0);
    in_port = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) in_port = 1'b1;
      cycle();
      address = 2'd0;
      #1;
      total++;
      if (readdata !== 32'd1) begin
        bad++;
        $display("FAIL glitch_data cyc=%0d got=%h want=1", i, readdata);
      end
      address = 2'd3;
      #1;
      total++;
      if (readdata !== 32'd0) begin
        bad++;
        $display("FAIL glitch_cap cyc=%0d got=%h want=0", i, readdata);
      end
    end
    in_port = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      cycle();
      n++;
      if (n == 6) in_port = 1'b1;
      if (readdata === 32'd1) seen = 1'b1;
    end
    total++;
    if (!seen || n != 7) begin
      bad++;
      $display("FAIL pulse_latency got=%0d want=7", n);
    end
  endtask
`endif

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        in_port = 1'($urandom);
        hold = $urandom_range(1, LAT + 5);
      end
      hold--;
      address   = 2'($urandom);
      writedata = $urandom;
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = ~chipselect | 1'($urandom_range(0, 3) == 0);
      cycle();
      chipselect = 1'b0;
      write_n    = 1'b1;
      #1;
      total++;
      if (irq !== (m_cap & m_mask) || readdata !== exp_read(address)) begin
        bad++;
        $display("FAIL random cyc=%0d addr=%0d got rd=%h irq=%b want rd=%h irq=%b", i, address,
                 readdata, irq, exp_read(address), m_cap & m_mask);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rexp [4];
    rexp = '{32'd1, 32'd0, 32'd0, 32'd0};
    bus_write(2'd2, 32'd1);
    settle_high();
    in_port = 1'b0;
    repeat (LAT + 6) cycle();
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_irq got=%b want=1", irq);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL mid_irq_drop got=%b want=0", irq);
    end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #0.5;
      total++;
      if (readdata !== rexp[a]) begin
        bad++;
        $display("FAIL mid_reset_read addr=%0d got=%h want=%h", a, readdata, rexp[a]);
      end
    end
    @(negedge clk);
    repeat (2) cycle();
    reset_n = 1'b1;
    address = 2'd3;
    for (int i = 1; i <= int'(3 + LAT); i++) begin
      cycle();
      total++;
      if (readdata !== {31'd0, i == int'(3 + LAT)}) begin
        bad++;
        $display("FAIL release_low cyc=%0d got=%h want=%0d", i, readdata, i == int'(3 + LAT));
      end
    end
    bus_write(2'd3, 32'd0);
    repeat (LAT + 8) cycle();
    address = 2'd3;
    #1;
    total++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL release_single_edge got cap=%h irq=%b want cap=0 irq=0", readdata, irq);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_edge();
    test_mask();
    test_clear_collision();
`ifdef NRF_IRQ_DEBOUNCE_EN
    test_glitch();
`endif
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
